fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Drains bytes from the 8-deep `fifo` block and serialises each one as a UART 8N1 frame on a single output line. It sits directly downstream of the FIFO. It drives the FIFO's `rd_en` and watches its `empty` flag, so the FIFO can buffer bursts from the producer while this block emits them at the configured baud rate. One frame is in flight at a time. Reads are issued only when the transmitter is idle and enabled.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per UART bit. Legal range is 2 to 65535.
- `WIDTH`, default 8: data bits per frame. Must equal the FIFO data width.

Ports (reset `rst` is synchronous, active-high; clock is `clk`):
- `clk`, input, 1: system clock. Same clock as the FIFO.
- `rst`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: permits starting a new frame. Does not abort a frame already in progress.
- `fifo_empty`, input, 1: the FIFO `empty` flag.
- `fifo_rd_data`, input, WIDTH: the FIFO `rd_data`. Registered by the FIFO, valid the cycle after `rd_en`.
- `fifo_rd_en`, output, 1: read strobe to the FIFO. Combinational, at most one cycle per frame.
- `tx`, output, 1: serial line. Idles high.
- `busy`, output, 1: high whenever the state is not IDLE.
- `frame_done`, output, 1: single-cycle pulse in the last cycle of the stop bit.

## Operation
- **States:** IDLE, LOAD, START, DATA, STOP. Encoded in 3 bits. Unused encodings go to IDLE.
- **IDLE:**
  - `tx`=1.
  - `fifo_rd_en` = `enable && !fifo_empty`.
  - If `fifo_rd_en` is high, go to LOAD. Otherwise stay in IDLE.
- **LOAD:**
  - `tx`=1.
  - `fifo_rd_data` is valid in this cycle. Capture it into a WIDTH-bit shift register.
  - Clear the bit counter and the bit index. Go to START.
- **START:**
  - `tx`=0 for CLKS_PER_BIT cycles.
  - Then go to DATA with bit index 0.
- **DATA:**
  - `tx` = shift register bit 0, i.e. data is sent LSB-first.
  - Each bit lasts CLKS_PER_BIT cycles. At the end of each bit, shift right by one and increment the index.
  - After bit WIDTH-1 completes, go to STOP.
- **STOP:**
  - `tx`=1 for CLKS_PER_BIT cycles.
  - `frame_done`=1 in the final cycle only. Then go to IDLE.
- **Bit timer:** `$clog2(CLKS_PER_BIT)`-bit counter.
  - Counts 0 to CLKS_PER_BIT-1, then wraps to 0 at the bit boundary.
  - No off-by-one: each bit is exactly CLKS_PER_BIT cycles.
- **Read-enable rules:**
  - `fifo_rd_en` is never asserted outside IDLE.
  - `fifo_rd_en` is never asserted while `fifo_empty` is high, so the FIFO never sees a read on empty.
  - `fifo_empty` is ignored in every state except IDLE.
- **enable deasserted mid-frame:** the current frame completes unchanged. No new read is issued until `enable` returns.
- **fifo_empty rising in the same IDLE cycle:** no read and no frame. Re-evaluate next cycle.

## Timing
- **Reset values** (applied at the first clk edge with `rst`=1, including mid-frame):
  - state=IDLE, `tx`=1, `busy`=0, `frame_done`=0, `fifo_rd_en`=0.
  - Counters and the shift register = 0.
  - A partially sent byte is discarded and not retried.
  - While `rst` is high, `fifo_rd_en` is forced to 0.
- **Latency:** if the read cycle is cycle R, `tx` falls at the start of cycle R+2. The stop bit ends at the end of cycle R+1+10·CLKS_PER_BIT.
- **Per-frame period:** 10·CLKS_PER_BIT + 2 cycles. The IDLE and LOAD cycles form a fixed 2-cycle high gap between back-to-back frames.
- **`busy`:** high from LOAD through the end of STOP. Low in IDLE, including the read cycle.
- **`frame_done`:** coincides with the last STOP cycle. The next `fifo_rd_en` can occur at the earliest in the following cycle.

## Test plan
- **Reset idle.** Assert `rst` for 3 cycles with `fifo_empty`=1.
  - Required: `tx`=1, `busy`=0, `fifo_rd_en`=0 throughout.
  - After release, nothing is sent.
- **Single byte.** Set CLKS_PER_BIT=4 and FIFO-loaded byte 0xA5.
  - Required: exactly one `fifo_rd_en` pulse.
  - `tx` sequence is 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles, starting at R+2.
  - `frame_done` pulses at cycle R+41.
- **Back-to-back.** Load 0x00, 0xFF, 0x3C with CLKS_PER_BIT=4.
  - Required: three frames in order, each 42 cycles apart.
  - 2 high cycles between each stop bit and the next start bit.
  - `fifo_rd_en` pulses occur in 3 separate cycles, never while empty.
- **Enable gating.** Load 2 bytes with CLKS_PER_BIT=4 and drop `enable` during the first frame's DATA state.
  - Required: the first frame completes, and no second read occurs.
  - Re-asserting `enable` starts the second frame 2 cycles after the read.
- **Reset mid-frame.** Assert `rst` for 1 cycle during DATA bit 3.
  - Required: `tx`=1 and `busy`=0 on the next cycle.
  - Remaining FIFO bytes are then sent normally, beginning with the byte after the aborted one.
- **Full drain.** Fill the FIFO to 8 entries (`full`=1) with 0x01..0x08, with `enable` held high.
  - Required: 8 frames with correct values.
  - `fifo_empty` rises after the 8th read, and `tx` stays high afterwards.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter draining a registered-read FIFO; tx falls 2 cycles after the read strobe.
// Backpressure: reads only from IDLE when enabled and non-empty, one frame in flight, 10*CLKS_PER_BIT+2 cycle period.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int WIDTH        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_rd_data,
   output logic             fifo_rd_en,
   output logic             tx,
   output logic             busy,
   output logic             frame_done
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    bit_cnt;
   logic [IW-1:0]    bit_idx;
   logic [WIDTH-1:0] shreg;
   logic             bit_last;
   logic             idx_last;
   logic             rd_go;

   assign bit_last = (bit_cnt == CW'(CLKS_PER_BIT - 1));
   assign idx_last = (bit_idx == IW'(WIDTH - 1));
   // reset gates the strobe so the FIFO never loses a byte while we are held
   assign rd_go    = (state == IDLE) && enable && !fifo_empty && !rst;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            LOAD: begin
               shreg   <= fifo_rd_data;
               bit_cnt <= '0;
               bit_idx <= '0;
            end
            START: begin
               bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
               if (bit_last) bit_idx <= '0;
            end
            DATA: begin
               bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
               if (bit_last) begin
                  shreg   <= shreg >> 1;
                  bit_idx <= bit_idx + 1'b1;
               end
            end
            STOP: begin
               bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt  = state;
      tx         = 1'b1;
      fifo_rd_en = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            fifo_rd_en = rd_go;
            if (rd_go) state_nxt = LOAD;
         end
         LOAD: begin
            state_nxt = START;
         end
         START: begin
            tx = 1'b0;
            if (bit_last) state_nxt = DATA;
         end
         DATA: begin
            tx = shreg[0];
            if (bit_last && idx_last) state_nxt = STOP;
         end
         STOP: begin
            frame_done = bit_last;
            if (bit_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural registered-read FIFO feeding it.
module tb_fifo_uart_tx;
   localparam int CPB = 4;
   localparam int FRAME_K = 1 + 10 * CPB;   // cycles after the read cycle up to frame_done

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b1;
   logic       fifo_empty;
   logic [7:0] fifo_rd_data = 8'h00;
   logic       fifo_rd_en;
   logic       tx;
   logic       busy;
   logic       frame_done;

   logic [7:0] mem [0:63];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         rd_on_empty = 0;

   always #5 clk = ~clk;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .WIDTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .tx           (tx),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
         fifo_rd_data <= mem[rd_ptr];
         rd_ptr       <= rd_ptr + 1;
      end
   end

   always @(negedge clk) begin
      if (fifo_rd_en && fifo_empty) rd_on_empty <= rd_on_empty + 1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr      = wr_ptr + 1;
   endtask

   // Waits (bounded) for the read strobe, then checks every cycle of the frame.
   task automatic frame(input string tag, input logic [7:0] exp_b, input int max_wait,
                        output int r_cyc);
      int n, bad_tx, bad_busy, bad_rd, bad_done, pos;
      logic       exp_tx;
      logic [7:0] got;
      n = 0; bad_tx = 0; bad_busy = 0; bad_rd = 0; bad_done = 0; got = 8'h00;
      #1;
      while (!fifo_rd_en && n < max_wait) begin
         @(negedge clk);
         n++;
      end
      r_cyc = cyc;
      if (!fifo_rd_en) begin
         chk({tag, "_rd_timeout"}, 32'd0, 32'd1);
         return;
      end
      chk({tag, "_busy_at_read"}, {31'd0, busy}, 32'd0);
      for (int k = 1; k <= FRAME_K; k++) begin
         @(negedge clk);
         if (k == 1)                  exp_tx = 1'b1;
         else if (k <= 1 + CPB)       exp_tx = 1'b0;
         else if (k <= 1 + 9 * CPB) begin
            pos    = k - 2 - CPB;
            exp_tx = exp_b[pos / CPB];
            if (pos % CPB == CPB / 2) got[pos / CPB] = tx;
         end else                     exp_tx = 1'b1;
         if (tx !== exp_tx) bad_tx++;
         if (busy !== 1'b1) bad_busy++;
         if (fifo_rd_en !== 1'b0) bad_rd++;
         if (frame_done !== (k == FRAME_K)) bad_done++;
      end
      chk({tag, "_byte"}, {24'd0, got}, {24'd0, exp_b});
      chk({tag, "_tx_cycles_wrong"}, bad_tx, 0);
      chk({tag, "_busy_cycles_wrong"}, bad_busy, 0);
      chk({tag, "_rd_in_frame"}, bad_rd, 0);
      chk({tag, "_done_cycles_wrong"}, bad_done, 0);
   endtask

   // Watches an idle line for n cycles: no reads, no busy, tx high.
   task automatic quiet(input string tag, input int n);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || frame_done !== 1'b0) bad++;
      end
      chk({tag, "_quiet_cycles_wrong"}, bad, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation stuck at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int r0, r1, r2, bad;
      bad = 0;

      // reset with an empty FIFO
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
      end
      chk("reset_idle_cycles_wrong", bad, 0);
      chk("reset_tx", {31'd0, tx}, 32'd1);
      rst = 1'b0;
      quiet("post_reset", 10);

      // single byte
      push(8'hA5);
      frame("single", 8'hA5, 5, r0);
      quiet("after_single", 20);

      // back-to-back frames
      @(negedge clk);
      push(8'h00); push(8'hFF); push(8'h3C);
      frame("b2b0", 8'h00, 5, r0);
      frame("b2b1", 8'hFF, 5, r1);
      frame("b2b2", 8'h3C, 5, r2);
      chk("b2b_period_01", r1 - r0, 42);
      chk("b2b_period_12", r2 - r1, 42);
      quiet("after_b2b", 10);

      // enable dropped mid-frame
      @(negedge clk);
      push(8'h11); push(8'h22);
      fork
         frame("gate0", 8'h11, 5, r0);
         begin
            repeat (15) @(negedge clk);
            enable = 1'b0;
         end
      join
      quiet("gated", 20);
      chk("gated_fifo_not_empty", {31'd0, fifo_empty}, 32'd0);
      enable = 1'b1;
      frame("gate1", 8'h22, 5, r1);

      // reset during DATA bit 3, with bytes still waiting
      @(negedge clk);
      push(8'h5A); push(8'h96); push(8'hC3);
      #1;
      chk("mid_rst_read", {31'd0, fifo_rd_en}, 32'd1);
      repeat (2 + CPB + 3 * CPB + 1) @(negedge clk);
      chk("mid_rst_in_data", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_tx", {31'd0, tx}, 32'd1);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_rd_forced", {31'd0, fifo_rd_en}, 32'd0);
      rst = 1'b0;
      frame("mid_rst1", 8'h96, 5, r0);
      frame("mid_rst2", 8'hC3, 5, r1);
      quiet("after_mid_rst", 10);

      // full 8-entry drain
      @(negedge clk);
      for (int i = 1; i <= 8; i++) push(8'(i));
      for (int i = 1; i <= 8; i++) frame($sformatf("drain%0d", i), 8'(i), 5, r0);
      chk("drain_empty", {31'd0, fifo_empty}, 32'd1);
      quiet("after_drain", 30);
      chk("rd_on_empty", rd_on_empty, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
